debug_scan_reader: RTL
======================

// Module: debug_scan_reader
// PURPOSE
//  Reader-side counterpart of the SNN debug output mux. Sequences the mux select code, waits for
//  the selected 8-bit debug value to settle, captures it and streams it as a framed byte stream
//  over a valid/ready interface toward the host link.
//  Frame format: header 0xA5, N data bytes, XOR checksum of the data bytes.
//  Full scan: N=18. Single mode: N=1.
// PARAMETERS
//  DATA_W        8   width of debug value, select code and stream bytes
//  NUM_SEL       18  data bytes per full scan (16 membrane slices + layer1 + layer2 spikes)
//  SAMPLE_DELAY  2   cycles from the cfg_en cycle to the dbg_in capture edge (>=1)
// PORTS
//  clk          in   1       clock
//  rst          in   1       asynchronous, active-high reset
//  start        in   1       pulse; accepted only when busy==0
//  single_mode  in   1       sampled with start; 1 = read single_sel only
//  single_sel   in   DATA_W  select code used in single mode; sampled with start
//  abort        in   1       terminate frame immediately
//  cfg_out      out  DATA_W  select code driven to the mux config register
//  cfg_en       out  1       one-cycle write strobe for cfg_out
//  dbg_in       in   DATA_W  debug value returned by the mux
//  tx_data      out  DATA_W  stream byte
//  tx_valid     out  1       stream byte valid
//  tx_ready     in   1       downstream accepts byte
//  tx_last      out  1       high with the checksum byte
//  busy         out  1       high from start acceptance to the final transfer or abort
//  done         out  1       one-cycle pulse in the cycle after the checksum transfer
// BEHAVIOUR
//  - Reset: all outputs 0 and FSM in IDLE. Reset mid-frame discards the frame; no done pulse.
//  - Select map, by index i:
//      i=0..15 -> code i
//      i=16    -> 8'h1F (layer1 spikes)
//      i=17    -> 8'h20 (layer2 spikes)
//  - FSM states: IDLE, HDR, SET, WAIT, CAPT, SEND, CSUM.
//  - IDLE:
//      on start: latch mode and single_sel, set busy, clear csum, set i=0, go to HDR.
//  - HDR:
//      tx_valid=1 with tx_data=0xA5; on transfer go to SET.
//  - SET (one cycle):
//      cfg_out = map(i), or the latched single_sel in single mode; cfg_en=1; go to WAIT.
//  - WAIT:
//      hold SAMPLE_DELAY-1 cycles, then go to CAPT.
//  - CAPT:
//      tx_data <= dbg_in and csum <= csum ^ dbg_in on the capture edge; go to SEND.
//      The capture edge is exactly SAMPLE_DELAY cycles after the cfg_en cycle.
//  - SEND:
//      tx_valid=1. On transfer: if i==N-1 go to CSUM, else increment i and go to SET.
//  - CSUM:
//      tx_data=csum, tx_last=1; on transfer: busy<=0, done<=1, go to IDLE.
//  - Handshake: a transfer occurs when tx_valid && tx_ready. Until then tx_data/tx_last hold stable.
//  - Backpressure never re-issues cfg_en. dbg_in is sampled exactly once per data byte.
//  - cfg_out holds its last value after cfg_en drops, including after the frame ends.
//  - abort: takes priority over a same-cycle transfer.
//      Next cycle: tx_valid=0, tx_last=0, busy=0, FSM in IDLE, no done pulse.
//      cfg_out is unchanged. This is the only case where tx_valid drops without a transfer.
//  - start while busy is ignored. start and abort together in IDLE: abort wins, start is ignored.
//  - i wraps from NUM_SEL-1 to 0 only via IDLE. i never exceeds NUM_SEL-1.
//  - Checksum: 8-bit XOR of the data bytes only, initial value 0x00, header excluded.
// STRUCTURE
//  - Shared package debug_pkg:
//      DBG_HDR=8'hA5, SEL_L1=8'h1F, SEL_L2=8'h20, NUM_MEM_SLICES=16
//      enum dbg_rd_state_t
//      function sel_map(idx)
//  - One sub-module, dbg_byte_stream_reg: tx_data/tx_valid/tx_last holding register with a load
//    port and valid/ready release. The FSM, index counter, wait counter and checksum stay at top.
// TESTING
//  1. Full scan: tx_ready=1; mux model returns 3*code for codes 0..15, 0x11 for 0x1F, 0x22 otherwise.
//     -> stream A5,00,03,..,2D,11,22,03; tx_last only on 03; 18 cfg_en pulses; done one cycle later.
//  2. Single mode, single_sel=0x07, model value 0x5C.
//     -> cfg_out=07 with one cfg_en; stream A5,5C,5C; tx_last on the third byte.
//  3. tx_ready low for 5 cycles on data byte 3.
//     -> tx_data holds 0x06; no extra cfg_en; the remaining stream is identical to scenario 1.
//  4. Change dbg_in one cycle before, at, and after the capture edge (SAMPLE_DELAY=2).
//     -> the captured byte equals the value present at cfg_en cycle + 2.
//  5. start pulsed mid-frame -> ignored. abort on data byte 5 -> next cycle tx_valid=0, busy=0,
//     no done; a new start then produces a full correct frame.
//  6. rst asserted mid-WAIT -> all outputs 0 immediately. After release: IDLE, and start works.

Source files
------------

// File: rtl/debug_pkg.sv
// debug_pkg: shared constants, reader FSM states and select-code map for the debug scan path
package debug_pkg;
  localparam logic [7:0] DBG_HDR = 8'hA5;
  localparam logic [7:0] SEL_L1 = 8'h1F;
  localparam logic [7:0] SEL_L2 = 8'h20;
  localparam int NUM_MEM_SLICES = 16;
  typedef enum logic [2:0] {IDLE, HDR, SET, WAIT, CAPT, SEND, CSUM} dbg_rd_state_t;
  function automatic logic [7:0] sel_map(input logic [4:0] idx);
    return (int'(idx) < NUM_MEM_SLICES) ? {3'b000, idx} : (int'(idx) == NUM_MEM_SLICES) ? SEL_L1 : SEL_L2;
  endfunction
endpackage

// File: rtl/dbg_byte_stream_reg.sv
// dbg_byte_stream_reg: holds one stream byte with its last flag until the valid/ready transfer
module dbg_byte_stream_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              clear,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              tx_last
);
  logic [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d;
  logic rel;
  assign rel = valid_q && tx_ready;
  always_comb begin
    data_d = load ? load_data : data_q;
    valid_d = clear ? 1'b0 : load ? 1'b1 : rel ? 1'b0 : valid_q;
    last_d = clear ? 1'b0 : load ? load_last : rel ? 1'b0 : last_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      data_q <= data_d;
      valid_q <= valid_d;
      last_q <= last_d;
    end
  end
  assign tx_data = data_q;
  assign tx_valid = valid_q;
  assign tx_last = last_q;
endmodule

// File: rtl/debug_scan_reader.sv
// debug_scan_reader: sequences debug mux selects, captures each value and streams a framed, checksummed byte stream
module debug_scan_reader
  import debug_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_SEL = 18,
  parameter int SAMPLE_DELAY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              single_mode,
  input  logic [DATA_W-1:0] single_sel,
  input  logic              abort,
  output logic [DATA_W-1:0] cfg_out,
  output logic              cfg_en,
  input  logic [DATA_W-1:0] dbg_in,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic              done
);
  dbg_rd_state_t state_q, state_d;
  logic [4:0] idx_q, idx_d, last_idx;
  logic [7:0] wait_q, wait_d;
  logic [DATA_W-1:0] csum_q, csum_d, sel_q, sel_d, cfg_out_q, cfg_out_d, ld_data;
  logic single_q, single_d, cfg_en_q, cfg_en_d, done_q, done_d;
  logic ld, ld_last, clr, xfer;
  assign xfer = tx_valid && tx_ready;
  assign last_idx = single_q ? 5'd0 : 5'(NUM_SEL - 1);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    wait_d = wait_q;
    csum_d = csum_q;
    single_d = single_q;
    sel_d = sel_q;
    ld = 1'b0;
    ld_data = csum_q;
    ld_last = 1'b0;
    clr = 1'b0;
    done_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
      clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          single_d = single_mode;
          sel_d = single_sel;
          csum_d = '0;
          idx_d = '0;
          ld = 1'b1;
          ld_data = DATA_W'(DBG_HDR);
          state_d = HDR;
        end
        HDR: state_d = xfer ? SET : HDR;
        SET: begin
          wait_d = '0;
          state_d = (SAMPLE_DELAY == 1) ? CAPT : WAIT;
        end
        WAIT: begin
          wait_d = wait_q + 8'd1;
          state_d = (wait_q == 8'(SAMPLE_DELAY - 2)) ? CAPT : WAIT;
        end
        CAPT: begin
          ld = 1'b1;
          ld_data = dbg_in;
          csum_d = csum_q ^ dbg_in;
          state_d = SEND;
        end
        SEND: if (xfer) begin
          if (idx_q == last_idx) begin
            ld = 1'b1;
            ld_last = 1'b1;
            state_d = CSUM;
          end else begin
            idx_d = idx_q + 5'd1;
            state_d = SET;
          end
        end
        CSUM: if (xfer) begin
          done_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    cfg_en_d = (state_d == SET);
    cfg_out_d = cfg_en_d ? (single_q ? sel_q : DATA_W'(sel_map(idx_d))) : cfg_out_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      wait_q <= '0;
      csum_q <= '0;
      single_q <= 1'b0;
      sel_q <= '0;
      cfg_out_q <= '0;
      cfg_en_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      wait_q <= wait_d;
      csum_q <= csum_d;
      single_q <= single_d;
      sel_q <= sel_d;
      cfg_out_q <= cfg_out_d;
      cfg_en_q <= cfg_en_d;
      done_q <= done_d;
    end
  end
  dbg_byte_stream_reg #(.DATA_W(DATA_W)) u_stream (
    .clk(clk),
    .rst(rst),
    .load(ld),
    .load_data(ld_data),
    .load_last(ld_last),
    .clear(clr),
    .tx_ready(tx_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_last(tx_last)
  );
  assign cfg_out = cfg_out_q;
  assign cfg_en = cfg_en_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;
endmodule
